instr_fetch_uart: RTL and testbench

INSTR_FETCH_UART -- requirements
Module: instr_fetch_uart

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_timer.sv | 23 ++
 rtl/instr_fetch_uart.sv | 105 ++++++++++
 tb/tb_instr_fetch_uart.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and parameter defaults for the UART instruction fetcher
package fetch_pkg;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT_TX   = 3'd2;
  localparam logic [2:0] S_WAIT_HI   = 3'd3;
  localparam logic [2:0] S_WAIT_LO   = 3'd4;
  localparam logic [2:0] S_PRESENT   = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000000;
  localparam int unsigned MAX_RETRY_DEF      = 2;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: per-state wait counter that clears on state entry and saturates at its expiry value
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == LAST;
  // count while enabled, hold once expired so the count never wraps
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/instr_fetch_uart.sv
// instr_fetch_uart: sends an address byte over UART, collects a two-byte instruction, retries on timeout
module instr_fetch_uart
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pc,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic        busy,
  output logic        timeout_err
);
  localparam int unsigned RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  logic [2:0]    state_q, state_d, retry_tgt;
  logic [7:0]    pc_q, pc_d, hi_q, hi_d, tx_data_q, tx_data_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   instr_q, instr_d;
  logic          tx_start_q, tx_start_d, instr_valid_q, instr_valid_d;
  logic          busy_q, busy_d, timeout_err_q, timeout_err_d;
  logic          waiting, expired, awaited, timeout, launch;
  assign waiting   = state_q inside {S_WAIT_TX, S_WAIT_HI, S_WAIT_LO};
  assign awaited   = state_q == S_WAIT_TX ? tx_done : rx_done;
  assign timeout   = waiting && expired && !awaited;
  assign launch    = start && (state_q == S_IDLE || state_q == S_ERROR);
  assign retry_tgt = retry_q < RMAX ? S_SEND_ADDR : S_ERROR;
  fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (state_d != state_q),
    .en     (waiting),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state: the awaited pulse always beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERROR: state_d = start ? S_SEND_ADDR : state_q;
      S_SEND_ADDR:     state_d = S_WAIT_TX;
      S_WAIT_TX:       state_d = tx_done ? S_WAIT_HI : timeout ? retry_tgt : state_q;
      S_WAIT_HI:       state_d = rx_done ? S_WAIT_LO : timeout ? retry_tgt : state_q;
      S_WAIT_LO:       state_d = rx_done ? S_PRESENT : timeout ? retry_tgt : state_q;
      S_PRESENT:       state_d = instr_ack ? S_IDLE : state_q;
      default:         state_d = S_IDLE;
    endcase
  end
  // datapath: address latch, saturating retry count, byte capture (high byte dropped on a low-byte timeout)
  always_comb begin
    pc_d    = launch ? pc : pc_q;
    retry_d = launch ? '0 : (timeout && retry_q != RMAX) ? retry_q + 1'b1 : retry_q;
    hi_d    = (state_q == S_WAIT_HI && rx_done) ? rx_data : (state_q == S_WAIT_LO && timeout) ? '0 : hi_q;
    instr_d = (state_q == S_WAIT_LO && rx_done) ? {hi_q, rx_data} : instr_q;
  end
  // outputs decoded from the next state so they register in step with the state
  always_comb begin
    tx_start_d    = state_d == S_SEND_ADDR;
    tx_data_d     = state_d inside {S_SEND_ADDR, S_WAIT_TX, S_WAIT_HI, S_WAIT_LO} ? pc_d : tx_data_q;
    instr_valid_d = state_d == S_PRESENT;
    busy_d        = !(state_d inside {S_IDLE, S_ERROR});
    timeout_err_d = state_d == S_ERROR;
  end
  // datapath and output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q          <= '0;
      retry_q       <= '0;
      hi_q          <= '0;
      instr_q       <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      retry_q       <= retry_d;
      hi_q          <= hi_d;
      instr_q       <= instr_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_instr_fetch_uart.sv
// tb_instr_fetch_uart: table-driven fetches plus retry, error, stray-event and reset sequences
module tb_instr_fetch_uart;
  logic        clk = 0, reset = 0, start = 0, tx_done = 0, rx_done = 0, instr_ack = 0;
  logic [7:0]  pc = 0, rx_data = 0, tx_data;
  logic        tx_start, instr_valid, busy, timeout_err;
  logic [15:0] instr;
  int          tests = 0, fails = 0, tx_pulses = 0, last_tx = 0, prev_tx = 0, cycle = 0;
  logic        tx_prev = 0, v_prev = 0;
  logic [15:0] exp_q[$];
  typedef struct {
    logic [7:0]  pc, hi, lo;
    int          txd, ackd;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[4];

  instr_fetch_uart #(.TIMEOUT_CYCLES(100), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done), .instr(instr),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cycle++;
    if (tx_start) begin
      check("tx_start single cycle", tx_prev, 0);
      tx_pulses++;
      prev_tx = last_tx;
      last_tx = cycle;
    end
    if (instr_valid && !v_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: unexpected instr %0h", instr);
      end else check("scoreboard instr", instr, exp_q.pop_front());
    end
    tx_prev = tx_start;
    v_prev  = instr_valid;
  end

  task automatic launch(input logic [7:0] a);
    pc = a;
    start = 1;
    cyc;
    start = 0;
    check("launch tx_start", tx_start, 1);
    check("launch tx_data", tx_data, a);
    check("launch busy", busy, 1);
  endtask

  task automatic reply(input logic [7:0] hi, lo, input int txd, hgap, ackd, input bit stray, smid);
    logic ok = 1;
    repeat (txd) cyc;
    tx_done = 1;
    if (stray) begin rx_data = 8'hEE; rx_done = 1; end
    cyc;
    tx_done = 0;
    rx_done = 0;
    repeat (hgap) cyc;
    rx_data = hi;
    rx_done = 1;
    cyc;
    rx_done = 0;
    repeat (2) cyc;
    rx_data = lo;
    rx_done = 1;
    cyc;
    rx_done = 0;
    check("instr_valid latency", instr_valid, 1);
    check("instr value", instr, {hi, lo});
    for (int i = 0; i < ackd; i++) begin
      if (smid && i == 10) begin pc = 8'h77; start = 1; end
      cyc;
      start = 0;
      if (!instr_valid || instr !== {hi, lo} || tx_data !== dut.pc_q) ok = 0;
    end
    if (ackd > 0) check("held while unacked", ok, 1);
    instr_ack = 1;
    cyc;
    instr_ack = 0;
    check("valid drop after ack", instr_valid, 0);
    check("idle after ack", busy, 0);
    check("instr retained", instr, {hi, lo});
  endtask

  initial begin
    int p;
    vecs = '{'{8'h2A, 8'h12, 8'h34, 10, 0, 16'h1234},
             '{8'h00, 8'h00, 8'h01, 1, 1, 16'h0001},
             '{8'h80, 8'hFF, 8'h00, 3, 2, 16'hFF00},
             '{8'hC3, 8'hA5, 8'h5A, 100, 0, 16'hA55A}};
    repeat (3) cyc;
    check("reset tx_start", tx_start, 0);
    check("reset tx_data", tx_data, 0);
    check("reset instr", instr, 0);
    check("reset instr_valid", instr_valid, 0);
    check("reset busy", busy, 0);
    check("reset timeout_err", timeout_err, 0);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      p = tx_pulses;
      exp_q.push_back(vecs[i].exp);
      launch(vecs[i].pc);
      reply(vecs[i].hi, vecs[i].lo, vecs[i].txd, 2, vecs[i].ackd, 0, 0);
      check("vector send count", tx_pulses, p + 1);
    end
    rx_data = 8'hEE;
    rx_done = 1;
    cyc;
    rx_done = 0;
    cyc;
    check("stray rx idle busy", busy, 0);
    check("stray rx idle valid", instr_valid, 0);
    p = tx_pulses;
    exp_q.push_back(16'hBEEF);
    launch(8'h11);
    reply(8'hBE, 8'hEF, 5, 2, 50, 0, 1);
    check("start in present ignored", tx_pulses, p + 1);
    exp_q.push_back(16'h4321);
    launch(8'h5C);
    reply(8'h43, 8'h21, 4, 2, 0, 1, 0);
    p = tx_pulses;
    exp_q.push_back(16'h9ABC);
    launch(8'h66);
    reply(8'h9A, 8'hBC, 2, 99, 0, 0, 0);
    check("expiry pulse no retry", tx_pulses, p + 1);
    p = tx_pulses;
    exp_q.push_back(16'h0F0F);
    launch(8'h40);
    for (int i = 0; i < 300 && tx_pulses < p + 2; i++) cyc;
    check("retry resend", tx_pulses, p + 2);
    check("retry spacing", last_tx - prev_tx, 101);
    check("retry tx_data", tx_data, 8'h40);
    reply(8'h0F, 8'h0F, 10, 2, 0, 0, 0);
    check("retry no error", timeout_err, 0);
    check("retry total sends", tx_pulses, p + 2);
    p = tx_pulses;
    launch(8'h99);
    for (int i = 0; i < 400 && !timeout_err; i++) cyc;
    check("error flagged", timeout_err, 1);
    check("error busy", busy, 0);
    check("error send count", tx_pulses, p + 3);
    exp_q.push_back(16'h5555);
    launch(8'h05);
    check("recover clears err", timeout_err, 0);
    reply(8'h55, 8'h55, 1, 2, 0, 0, 0);
    launch(8'h31);
    repeat (2) cyc;
    tx_done = 1;
    cyc;
    tx_done = 0;
    cyc;
    rx_data = 8'h77;
    rx_done = 1;
    cyc;
    rx_done = 0;
    cyc;
    check("mid fetch busy", busy, 1);
    reset = 0;
    #1;
    check("async reset tx_start", tx_start, 0);
    check("async reset tx_data", tx_data, 0);
    check("async reset instr", instr, 0);
    check("async reset instr_valid", instr_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset timeout_err", timeout_err, 0);
    cyc;
    reset = 1;
    rx_data = 8'h22;
    rx_done = 1;
    cyc;
    rx_done = 0;
    cyc;
    check("post reset stray busy", busy, 0);
    check("post reset stray valid", instr_valid, 0);
    exp_q.push_back(16'hC0DE);
    launch(8'hFF);
    reply(8'hC0, 8'hDE, 10, 2, 0, 0, 0);
    repeat (2) cyc;
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
